// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
// Operand width default, FSM state encoding and the partial-product counter.
package mul_pkg;

  localparam int MUL_WIDTH = 8;
  localparam int CNT_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // Index of the last partial product (high x high)
  localparam cnt_t CNT_LAST = cnt_t'(3);

endpackage

// File: rtl/mul4x4.sv
// Combinational N x N unsigned multiplier shared across all partial products.
// Operands are zero-extended so the multiply is evaluated at full result width.
module mul4x4 #(
  parameter int N = 4
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] x_ext;
  logic [2*N-1:0] y_ext;

  assign x_ext = {{N{1'b0}}, x};
  assign y_ext = {{N{1'b0}}, y};
  assign p     = x_ext * y_ext;

endmodule

// File: rtl/mul8x8_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier: one shared half-width multiplier, four
// partial products accumulated over four CALC cycles, product held between runs.
//
// state | meaning
// IDLE  | waiting for st; operands captured on accept
// CALC  | one partial product per cycle, cnt selects which
// DONE  | product valid, done pulses for this cycle only
module mul8x8_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  state_t            state;
  cnt_t              cnt;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [PW-1:0]     acc;

  logic [HALF-1:0]   op_x;
  logic [HALF-1:0]   op_y;
  logic [WIDTH-1:0]  pp;
  logic [PW-1:0]     pp_ext;
  logic [PW-1:0]     pp_sh;
  logic [PW-1:0]     sum;

  // Operand select: low/high halves of a_r and b_r per partial-product index
  always_comb begin
    op_x = a_r[HALF-1:0];
    op_y = b_r[HALF-1:0];
    case (cnt)
      cnt_t'(0): begin
        op_x = a_r[HALF-1:0];
        op_y = b_r[HALF-1:0];
      end
      cnt_t'(1): begin
        op_x = a_r[WIDTH-1:HALF];
        op_y = b_r[HALF-1:0];
      end
      cnt_t'(2): begin
        op_x = a_r[HALF-1:0];
        op_y = b_r[WIDTH-1:HALF];
      end
      default: begin
        op_x = a_r[WIDTH-1:HALF];
        op_y = b_r[WIDTH-1:HALF];
      end
    endcase
  end

  mul4x4 #(
    .N (HALF)
  ) u_mul (
    .x (op_x),
    .y (op_y),
    .p (pp)
  );

  assign pp_ext = {{WIDTH{1'b0}}, pp};

  always_comb begin
    pp_sh = pp_ext;
    case (cnt)
      cnt_t'(0): pp_sh = pp_ext;
      cnt_t'(1),
      cnt_t'(2): pp_sh = pp_ext << HALF;
      default:   pp_sh = pp_ext << WIDTH;
    endcase
  end

  // Worst case (2^WIDTH-1)^2 fits in PW bits, so the carry-out is never needed
  assign sum = acc + pp_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (st) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          busy <= 1'b1;
          acc  <= sum;
          cnt  <= cnt + cnt_t'(1);
          if (cnt == CNT_LAST) begin
            product <= sum;
            state   <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul8x8_seq_ctrl.sv
// Directed bench for mul8x8_seq_ctrl: a vector table of operand pairs plus
// hand-written sequences for st-during-CALC, held st and mid-CALC reset.
module tb_mul8x8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        st;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_pass  = 0;
  int n_total = 0;

  mul8x8_seq_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .st      (st),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    bit          disturb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One operation with a single-cycle st pulse; checks latency, busy width,
  // product hold during CALC, result and the one-cycle done pulse.
  task automatic run_op(input vec_t v);
    logic [15:0] prev;
    int cycles;
    int busy_cnt;
    bit  hold_ok;
    prev     = product;
    hold_ok  = 1'b1;
    busy_cnt = 0;
    cycles   = 0;
    a  = v.a;
    b  = v.b;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      if (product !== prev) hold_ok = 1'b0;
      if (v.disturb && cycles == 1) begin
        a  = ~v.a;
        b  = v.b + 8'd7;
        st = 1'b1;
      end
      if (v.disturb && cycles == 3) st = 1'b0;
      @(negedge clk);
      cycles++;
    end
    if (busy) busy_cnt++;
    chk("done_latency", cycles, 4);
    chk("product_hold_in_calc", hold_ok, 1);
    chk("product", product, v.exp);
    chk("busy_width", busy_cnt, 5);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    st = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int done_at[$];
    int guard;
    bit stray_done;
    logic [15:0] prods[$];

    vecs[0] = '{8'h12, 8'h13, 16'h0156, 1'b0};
    vecs[1] = '{8'h23, 8'h12, 16'h0276, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[3] = '{8'h00, 8'hA5, 16'h0000, 1'b0};
    vecs[4] = '{8'h80, 8'h02, 16'h0100, 1'b0};
    vecs[5] = '{8'h0F, 8'hF0, 16'h0E10, 1'b0};
    vecs[6] = '{8'hAB, 8'hCD, 16'h88EF, 1'b0};
    vecs[7] = '{8'h12, 8'h13, 16'h0156, 1'b1};

    rst = 1'b1; st = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_product", product, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // st held high: a new operation every 6 cycles
    a = 8'h12; b = 8'h13; st = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(t);
        prods.push_back(product);
      end
    end
    st = 1'b0;
    chk("held_st_pulses", done_at.size(), 3);
    if (done_at.size() == 3) begin
      chk("held_st_t0", done_at[0], 4);
      chk("held_st_t1", done_at[1], 10);
      chk("held_st_t2", done_at[2], 16);
      for (int i = 0; i < 3; i++) chk("held_st_product", prods[i], 16'h0156);
    end
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("held_st_drain", busy, 0);
    @(negedge clk);

    // Reset at cnt=2 aborts the operation and clears product
    a = 8'hFF; b = 8'hFF; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_product", product, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    stray_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) stray_done = 1'b1;
    end
    chk("abort_stays_idle", stray_done, 0);
    run_op(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
